// File: rtl/axi_lite_sram.sv
// AXI4-Lite responder over a word-organised on-chip SRAM.
// Independent read/write channels with fixed programmable latencies.
module axi_lite_sram #(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          DEPTH  = 1024,
    parameter int          RD_LAT = 0,
    parameter int          WR_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [31:0] SPAN   = 32'(DEPTH * 4);
    localparam logic [3:0]  RL     = 4'(RD_LAT);
    localparam logic [3:0]  WL     = 4'(WR_LAT);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    r_state_t    r_state;
    logic [3:0]  r_cnt;
    logic [31:0] ar_q;
    logic        ar_hs;
    logic [31:0] r_addr;
    logic [31:0] r_off;
    logic        r_hit;
    logic [AW-1:0] r_idx;
    logic        r_load;

    w_state_t    w_state;
    logic [3:0]  w_cnt;
    logic        aw_got;
    logic        w_got;
    logic [31:0] aw_q;
    logic [31:0] wd_q;
    logic [3:0]  ws_q;
    logic        aw_hs;
    logic        w_hs;
    logic        both;
    logic [31:0] w_addr;
    logic [31:0] w_dat;
    logic [3:0]  w_stb;
    logic [31:0] w_off;
    logic        w_hit;
    logic [AW-1:0] w_idx;
    logic        w_commit;

    // Readies depend on state only; reset holds them low.
    assign arready = rst && (r_state == R_IDLE);
    assign awready = rst && (w_state == W_IDLE) && !aw_got;
    assign wready  = rst && (w_state == W_IDLE) && !w_got;

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Zero-latency reads sample using the live address.
    assign r_addr = (r_state == R_IDLE) ? araddr : ar_q;
    assign r_off  = r_addr - BASE;
    assign r_hit  = r_off < SPAN;
    assign r_idx  = r_off[AW+1:2];
    assign r_load = (r_state == R_IDLE && ar_hs && RL == 4'd0)
                 || (r_state == R_WAIT && r_cnt == 4'd1);

    // Captured fields win; otherwise use the handshake in progress.
    assign both   = (aw_got || aw_hs) && (w_got || w_hs);
    assign w_addr = aw_got ? aw_q : awaddr;
    assign w_dat  = w_got ? wd_q : wdata;
    assign w_stb  = w_got ? ws_q : wstrb;
    assign w_off  = w_addr - BASE;
    assign w_hit  = w_off < SPAN;
    assign w_idx  = w_off[AW+1:2];
    assign w_commit = (w_state == W_IDLE && both && WL == 4'd0)
                   || (w_state == W_WAIT && w_cnt == 4'd1);

    // Read channel FSM with registered response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_cnt   <= 4'd0;
            ar_q    <= 32'h0;
            rvalid  <= 1'b0;
            rdata   <= 32'h0;
            rresp   <= OKAY;
        end else begin
            if (r_load) begin
                rvalid <= 1'b1;
                rdata  <= r_hit ? mem[r_idx] : 32'h0;
                rresp  <= r_hit ? OKAY : DECERR;
            end
            unique case (r_state)
                R_IDLE: if (ar_hs) begin
                    ar_q    <= araddr;
                    r_cnt   <= RL;
                    r_state <= (RL == 4'd0) ? R_RESP : R_WAIT;
                end
                R_WAIT: begin
                    if (r_cnt == 4'd1) r_state <= R_RESP;
                    r_cnt <= r_cnt - 4'd1;
                end
                R_RESP: if (rready) begin
                    rvalid  <= 1'b0;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write channel FSM: capture AW/W independently, then respond.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state <= W_IDLE;
            w_cnt   <= 4'd0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_q    <= 32'h0;
            wd_q    <= 32'h0;
            ws_q    <= 4'h0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            if (w_commit) begin
                bvalid <= 1'b1;
                bresp  <= w_hit ? OKAY : DECERR;
            end
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_got <= 1'b1;
                        aw_q   <= awaddr;
                    end
                    if (w_hs) begin
                        w_got <= 1'b1;
                        wd_q  <= wdata;
                        ws_q  <= wstrb;
                    end
                    if (both) begin
                        w_cnt   <= WL;
                        w_state <= (WL == 4'd0) ? W_RESP : W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 4'd1) w_state <= W_RESP;
                    w_cnt <= w_cnt - 4'd1;
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    aw_got  <= 1'b0;
                    w_got   <= 1'b0;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-masked commit; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (rst && w_commit && w_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_stb[b]) mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench for axi_lite_sram: zero-latency instance (0)
// and a slow instance (1) with RD_LAT=3, WR_LAT=5.
module tb_axi_lite_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_sram #(.RD_LAT(0), .WR_LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]),
        .rready(rready[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]),
        .wready(wready[0]),
        .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
    );

    axi_lite_sram #(.RD_LAT(3), .WR_LAT(5)) dut1 (
        .clk(clk), .rst(rst),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]),
        .rready(rready[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]),
        .wready(wready[1]),
        .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rd;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input int s, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int lat,
                            input logic [1:0] resp);
        int  n;
        int  cyc;
        logic ah;
        logic wh;
        awaddr[s] = addr;
        wdata[s]  = data;
        wstrb[s]  = strb;
        wvalid[s] = 1'b1;
        if (lead > 0) begin
            @(posedge clk); #1;
            wvalid[s] = 1'b0;
            repeat (lead - 1) begin @(posedge clk); #1; end
            chk("w_first_wready", 32'(wready[s]), 32'd0);
            chk("w_first_awready", 32'(awready[s]), 32'd1);
            chk("w_first_bvalid", 32'(bvalid[s]), 32'd0);
        end
        awvalid[s] = 1'b1;
        n = 0;
        while ((awvalid[s] || wvalid[s]) && n < 20) begin
            ah = awvalid[s] && awready[s];
            wh = wvalid[s] && wready[s];
            @(posedge clk); #1;
            n++;
            if (ah) awvalid[s] = 1'b0;
            if (wh) wvalid[s] = 1'b0;
        end
        chk("wr_hs_timeout", 32'(n < 20), 32'd1);
        awvalid[s] = 1'b0;
        wvalid[s]  = 1'b0;
        cyc = 0;
        while (!bvalid[s] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("wr_latency", 32'(cyc), 32'(lat));
        chk("bresp", 32'(bresp[s]), 32'(resp));
        bready[s] = 1'b1;
        @(posedge clk); #1;
        bready[s] = 1'b0;
        chk("bvalid_drop", 32'(bvalid[s]), 32'd0);
    endtask

    task automatic do_read(input int s, input logic [31:0] addr,
                           input int lat, input int hold,
                           input logic [31:0] exp, input logic [1:0] resp);
        int  n;
        int  cyc;
        logic ok;
        araddr[s]  = addr;
        arvalid[s] = 1'b1;
        n = 0;
        while (arvalid[s] && n < 20) begin
            ok = arready[s];
            @(posedge clk); #1;
            n++;
            if (ok) arvalid[s] = 1'b0;
        end
        chk("rd_hs_timeout", 32'(n < 20), 32'd1);
        arvalid[s] = 1'b0;
        cyc = 0;
        while (!rvalid[s] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rd_latency", 32'(cyc), 32'(lat));
        chk("rresp", 32'(rresp[s]), 32'(resp));
        chk("rdata", rdata[s], exp);
        if (hold > 0) begin
            ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!rvalid[s] || rdata[s] !== exp || arready[s]) ok = 1'b0;
            end
            chk("rd_hold_stable", 32'(ok), 32'd1);
        end
        rready[s] = 1'b1;
        @(posedge clk); #1;
        rready[s] = 1'b0;
        chk("rvalid_drop", 32'(rvalid[s]), 32'd0);
        chk("arready_back", 32'(arready[s]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  quiet;
        for (int s = 0; s < 2; s++) begin
            araddr[s] = 32'h0; arvalid[s] = 1'b0; rready[s] = 1'b0;
            awaddr[s] = 32'h0; awvalid[s] = 1'b0; wdata[s] = 32'h0;
            wstrb[s] = 4'h0; wvalid[s] = 1'b0; bready[s] = 1'b0;
        end

        vec[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF};
        vec[1] = '{32'h8000_0000, 32'h0123_4567, 4'hF, 2'b00, 32'h0123_4567};
        vec[2] = '{32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'hCAFE_F00D};
        vec[3] = '{32'h8000_0FFF, 32'hAB00_0000, 4'h8, 2'b00, 32'hABFE_F00D};
        vec[4] = '{32'h8000_0004, 32'h5555_5555, 4'hF, 2'b00, 32'h5555_5555};
        vec[5] = '{32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h5555_5555};
        vec[6] = '{32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 2'b11, 32'h0};
        vec[7] = '{32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2'b11, 32'h0};
        vec[8] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 2'b11, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_valids", {rvalid[s], bvalid[s]}, 32'd0);
            chk("rst_readies", {arready[s], awready[s], wready[s]}, 32'd0);
            chk("rst_rdata", rdata[s], 32'h0);
            chk("rst_resps", {rresp[s], bresp[s]}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++)
            chk("idle_readies", {arready[s], awready[s], wready[s]}, 32'h7);

        for (int i = 0; i < 9; i++) begin
            do_write(0, vec[i].addr, vec[i].wd, vec[i].strb, 0, 0, vec[i].resp);
            do_read(0, vec[i].addr, 0, 0, vec[i].rd, vec[i].resp);
        end
        do_read(0, 32'h8000_0000, 0, 0, 32'h0123_4567, 2'b00);
        do_read(0, 32'h8000_0FFC, 0, 0, 32'hABFE_F00D, 2'b00);

        do_write(0, 32'h8000_0020, 32'hAAAA_AAAA, 4'hF, 0, 0, 2'b00);
        do_write(0, 32'h8000_0020, 32'h1122_3344, 4'b0101, 2, 0, 2'b00);
        do_read(0, 32'h8000_0020, 0, 0, 32'hAA22_AA44, 2'b00);

        fork
            do_write(0, 32'h8000_0010, 32'h1234_5678, 4'hF, 0, 0, 2'b00);
            do_read(0, 32'h8000_0010, 0, 0, 32'hDEAD_BEEF, 2'b00);
        join
        do_read(0, 32'h8000_0010, 0, 0, 32'h1234_5678, 2'b00);

        do_write(1, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 0, 5, 2'b00);
        do_read(1, 32'h8000_0040, 3, 5, 32'h0BAD_F00D, 2'b00);
        do_read(1, 32'h7FFF_FFFC, 3, 0, 32'h0, 2'b11);

        awaddr[1]  = 32'h8000_0040;
        wdata[1]   = 32'hFFFF_FFFF;
        wstrb[1]   = 4'hF;
        chk("abort_ready", {awready[1], wready[1]}, 32'h3);
        awvalid[1] = 1'b1;
        wvalid[1]  = 1'b1;
        @(posedge clk); #1;
        awvalid[1] = 1'b0;
        wvalid[1]  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_rst_readies", {awready[1], wready[1], arready[1]}, 32'd0);
        rst = 1'b1;
        quiet = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bvalid[1]) quiet++;
        end
        chk("abort_no_bvalid", 32'(quiet), 32'd0);
        do_read(1, 32'h8000_0040, 3, 0, 32'h0BAD_F00D, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
